hazard_tracker: RTL and testbench

//  Parametrised successor to the decode-stage instruction classifier. Carries each classified

---
 rtl/hazard_tracker_pkg.sv | 24 ++
 rtl/hazard_tracker_md_busy_counter.sv | 36 +++
 rtl/hazard_tracker.sv | 123 ++++++++++++
 tb/tb_hazard_tracker.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_tracker_pkg.sv
// Shared encodings for the decode-stage hazard tracker: func classes, mult/div op codes
// and stage entry field widths.
package hazard_tracker_pkg;

    localparam logic [2:0] FUNC_NONE   = 3'd0;
    localparam logic [2:0] FUNC_ALU    = 3'd1;
    localparam logic [2:0] FUNC_LOAD   = 3'd2;
    localparam logic [2:0] FUNC_STORE  = 3'd3;
    localparam logic [2:0] FUNC_BRANCH = 3'd4;
    localparam logic [2:0] FUNC_JUMP   = 3'd5;
    localparam logic [2:0] FUNC_MD     = 3'd6;
    localparam logic [2:0] FUNC_MOVE   = 3'd7;

    typedef enum logic [1:0] {
        MD_OP_NONE = 2'b00,
        MD_OP_MULT = 2'b01,
        MD_OP_DIV  = 2'b10,
        MD_OP_HILO = 2'b11
    } md_op_e;

    localparam int unsigned VALID_W = 1;
    localparam int unsigned REG_W   = 5;

endpackage

// File: rtl/hazard_tracker_md_busy_counter.sv
// HI/LO busy counter: loads the op latency on accept, then counts down to idle.
module md_busy_counter
    import hazard_tracker_pkg::*;
#(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             busy_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_tracker.sv
// Tracks classified instructions through the post-decode stages and resolves D-stage
// operand and HI/LO hazards into a stall plus per-operand forward selects.
module hazard_tracker
    import hazard_tracker_pkg::*;
#(
    parameter int unsigned NUM_STAGES  = 3,
    parameter int unsigned WIDTH_FUNC  = 3,
    parameter int unsigned TW          = 2,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned SELW        = $clog2(NUM_STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  d_valid,
    input  logic [WIDTH_FUNC-1:0] d_func,
    input  logic [1:0]            d_md_op,
    input  logic [4:0]            d_rs,
    input  logic [4:0]            d_rt,
    input  logic                  d_rs_use,
    input  logic                  d_rt_use,
    input  logic [TW-1:0]         d_rs_tuse,
    input  logic [TW-1:0]         d_rt_tuse,
    input  logic [4:0]            d_dst,
    input  logic [TW-1:0]         d_tnew,
    input  logic                  flush,
    output logic                  stall,
    output logic [SELW-1:0]       fwd_rs_sel,
    output logic [SELW-1:0]       fwd_rt_sel,
    output logic                  md_busy,
    output logic [WIDTH_FUNC-1:0] e_func
);

    localparam int unsigned CNT_W = $clog2(DIV_CYCLES + 1);

    typedef struct packed {
        logic [VALID_W-1:0]    valid;
        logic [WIDTH_FUNC-1:0] func;
        logic [REG_W-1:0]      dst;
        logic [TW-1:0]         tnew;
    } entry_t;

    typedef struct packed {
        logic            haz;
        logic [SELW-1:0] sel;
    } opnd_t;

    entry_t     stage_q [NUM_STAGES];
    entry_t     stage_d [NUM_STAGES];
    opnd_t      rs_res;
    opnd_t      rt_res;
    md_op_e     md_op;
    logic       md_hazard;
    logic       accept;
    logic       md_load;
    logic [CNT_W-1:0] md_load_val;

    // Walk oldest to youngest so the youngest matching writer overrides older ones.
    function automatic opnd_t resolve(input logic [REG_W-1:0] addr, input logic used,
                                      input logic [TW-1:0] tuse, input entry_t st [NUM_STAGES]);
        opnd_t r;
        r = '0;
        for (int unsigned k = NUM_STAGES; k > 0; k--) begin
            if (used && addr != '0 && st[k-1].valid != '0 && st[k-1].dst == addr) begin
                r.haz = (st[k-1].tnew > tuse);
                r.sel = (st[k-1].tnew == '0) ? SELW'(k) : '0;
            end
        end
        return r;
    endfunction

    always_comb begin
        rs_res      = resolve(d_rs, d_rs_use, d_rs_tuse, stage_q);
        rt_res      = resolve(d_rt, d_rt_use, d_rt_tuse, stage_q);
        md_op       = md_op_e'(d_md_op);
        md_hazard   = d_valid && (md_op != MD_OP_NONE) && md_busy;
        stall       = (d_valid && (rs_res.haz || rt_res.haz)) || md_hazard;
        fwd_rs_sel  = rs_res.sel;
        fwd_rt_sel  = rt_res.sel;
        accept      = d_valid && !stall && !flush;
        md_load     = accept && (md_op == MD_OP_MULT || md_op == MD_OP_DIV);
        md_load_val = (md_op == MD_OP_MULT) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
    end

    always_comb begin
        stage_d[0] = '0;
        if (accept) begin
            stage_d[0].valid = '1;
            stage_d[0].func  = d_func;
            stage_d[0].dst   = d_dst;
            stage_d[0].tnew  = d_tnew;
        end
        for (int unsigned k = 1; k < NUM_STAGES; k++) begin
            stage_d[k] = stage_q[k-1];
            if (stage_q[k-1].tnew != '0) begin
                stage_d[k].tnew = stage_q[k-1].tnew - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < NUM_STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign e_func = stage_q[0].func;

    md_busy_counter #(
        .CNT_W (CNT_W)
    ) u_md_busy_counter (
        .clk        (clk),
        .reset      (reset),
        .load_i     (md_load),
        .load_val_i (md_load_val),
        .busy_o     (md_busy)
    );

endmodule

// File: tb/tb_hazard_tracker.sv
// Scenario bench for hazard_tracker: per-cycle expectations go through a scoreboard queue.
module tb_hazard_tracker;
    import hazard_tracker_pkg::*;

    localparam int MULT_C = 5;
    localparam int DIV_C  = 10;

    typedef struct packed {
        logic       v;
        logic [2:0] func;
        logic [1:0] md;
        logic [4:0] rs;
        logic       rsu;
        logic [1:0] rst;
        logic [4:0] rt;
        logic       rtu;
        logic [1:0] rtt;
        logic [4:0] dst;
        logic [1:0] tnew;
        logic       fl;
    } instr_t;

    typedef struct packed {
        logic       stall;
        logic [1:0] rs;
        logic [1:0] rt;
        logic       busy;
        logic [2:0] ef;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    logic d_valid, d_rs_use, d_rt_use, flush;
    logic [2:0] d_func;
    logic [1:0] d_md_op, d_rs_tuse, d_rt_tuse, d_tnew;
    logic [4:0] d_rs, d_rt, d_dst;
    logic stall, md_busy;
    logic [1:0] fwd_rs_sel, fwd_rt_sel;
    logic [2:0] e_func;
    obs_t obs;

    int checks = 0;
    int errors = 0;
    obs_t sb [$];
    int   cnt_sb [$];

    always #5 clk = ~clk;

    assign obs = {stall, fwd_rs_sel, fwd_rt_sel, md_busy, e_func};

    hazard_tracker #(
        .NUM_STAGES  (3),
        .WIDTH_FUNC  (3),
        .TW          (2),
        .MULT_CYCLES (MULT_C),
        .DIV_CYCLES  (DIV_C)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .d_valid    (d_valid),
        .d_func     (d_func),
        .d_md_op    (d_md_op),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_rs_use   (d_rs_use),
        .d_rt_use   (d_rt_use),
        .d_rs_tuse  (d_rs_tuse),
        .d_rt_tuse  (d_rt_tuse),
        .d_dst      (d_dst),
        .d_tnew     (d_tnew),
        .flush      (flush),
        .stall      (stall),
        .fwd_rs_sel (fwd_rs_sel),
        .fwd_rt_sel (fwd_rt_sel),
        .md_busy    (md_busy),
        .e_func     (e_func)
    );

    function automatic instr_t bub();
        return '0;
    endfunction

    function automatic instr_t wr(logic [2:0] func, logic [4:0] dst, logic [1:0] tnew);
        instr_t r = '0;
        r.v = 1'b1; r.func = func; r.dst = dst; r.tnew = tnew;
        return r;
    endfunction

    function automatic instr_t rd(logic [2:0] func, logic [4:0] rs, logic rsu, logic [1:0] rst,
                                  logic [4:0] rt, logic rtu, logic [1:0] rtt,
                                  logic [4:0] dst, logic [1:0] tnew);
        instr_t r = wr(func, dst, tnew);
        r.rs = rs; r.rsu = rsu; r.rst = rst; r.rt = rt; r.rtu = rtu; r.rtt = rtt;
        return r;
    endfunction

    function automatic instr_t mdi(logic [1:0] md, logic [2:0] func, logic [4:0] dst);
        instr_t r = wr(func, dst, 2'd1);
        r.md = md;
        return r;
    endfunction

    function automatic obs_t exv(logic s, logic [1:0] rs, logic [1:0] rt, logic b, logic [2:0] ef);
        obs_t o;
        o.stall = s; o.rs = rs; o.rt = rt; o.busy = b; o.ef = ef;
        return o;
    endfunction

    function automatic string show(obs_t v);
        return $sformatf("stall=%b rs_sel=%0d rt_sel=%0d busy=%b efunc=%0d",
                         v.stall, v.rs, v.rt, v.busy, v.ef);
    endfunction

    task automatic drive(input instr_t i);
        d_valid = i.v;   d_func = i.func; d_md_op = i.md;
        d_rs = i.rs;     d_rs_use = i.rsu; d_rs_tuse = i.rst;
        d_rt = i.rt;     d_rt_use = i.rtu; d_rt_tuse = i.rtt;
        d_dst = i.dst;   d_tnew = i.tnew;  flush = i.fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        drive(bub());
        repeat (4) step();
    endtask

    task automatic test_reset();
        obs_t e;
        reset = 1'b1;
        drive(bub());
        for (int i = 0; i < 2; i++) begin
            sb.push_back(exv(0, 0, 0, 0, FUNC_NONE));
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL reset[%0d]: got %s, expected %s", i, show(obs), show(e));
            end
            @(posedge clk);
            #1 reset = 1'b0;
        end
    endtask

    task automatic test_reset_mid_div();
        instr_t st [5];
        obs_t   ex [5];
        obs_t   e;
        st[0] = mdi(MD_OP_DIV, FUNC_MD, 0); ex[0] = exv(0, 0, 0, 0, FUNC_NONE);
        st[1] = bub();                      ex[1] = exv(0, 0, 0, 1, FUNC_MD);
        st[2] = bub();                      ex[2] = exv(0, 0, 0, 1, FUNC_NONE);
        st[3] = wr(FUNC_ALU, 5, 1);         ex[3] = exv(0, 0, 0, 1, FUNC_NONE);
        st[4] = bub();                      ex[4] = exv(0, 0, 0, 1, FUNC_ALU);
        for (int i = 0; i < 5; i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL reset_mid_div[%0d]: got %s, expected %s", i, show(obs), show(e));
            end
            if (i < 4) step();
        end
        // counter sits at 7 here; reset lands before the next edge
        #1 reset = 1'b1;
        drive(rd(FUNC_MOVE, 5, 1, 0, 0, 0, 0, 0, 0));
        d_md_op = MD_OP_HILO;
        for (int i = 0; i < 2; i++) begin
            sb.push_back(exv(0, 0, 0, 0, FUNC_NONE));
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL reset_mid_div_after[%0d]: got %s, expected %s", i, show(obs), show(e));
            end
            @(posedge clk);
            #1 reset = 1'b0;
        end
        drain();
    endtask

    task automatic test_load_use();
        instr_t st [4];
        obs_t   ex [4];
        obs_t   e;
        st[0] = wr(FUNC_LOAD, 1, 2);                   ex[0] = exv(0, 0, 0, 0, FUNC_NONE);
        st[1] = rd(FUNC_ALU, 1, 1, 1, 0, 0, 0, 4, 1);  ex[1] = exv(1, 0, 0, 0, FUNC_LOAD);
        st[2] = st[1];                                 ex[2] = exv(0, 0, 0, 0, FUNC_NONE);
        st[3] = rd(FUNC_ALU, 1, 1, 1, 0, 0, 0, 6, 1);  ex[3] = exv(0, 3, 0, 0, FUNC_ALU);
        for (int i = 0; i < 4; i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL load_use[%0d]: got %s, expected %s", i, show(obs), show(e));
            end
            step();
        end
        drain();
    endtask

    task automatic test_branch_fwd();
        instr_t st [4];
        obs_t   ex [4];
        obs_t   e;
        st[0] = wr(FUNC_ALU, 2, 1);                      ex[0] = exv(0, 0, 0, 0, FUNC_NONE);
        st[1] = rd(FUNC_BRANCH, 2, 1, 0, 0, 0, 0, 0, 0); ex[1] = exv(1, 0, 0, 0, FUNC_ALU);
        st[2] = st[1];                                   ex[2] = exv(0, 2, 0, 0, FUNC_NONE);
        st[3] = bub();                                   ex[3] = exv(0, 0, 0, 0, FUNC_BRANCH);
        for (int i = 0; i < 4; i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL branch_fwd[%0d]: got %s, expected %s", i, show(obs), show(e));
            end
            step();
        end
        drain();
    endtask

    task automatic test_youngest();
        instr_t st [5];
        obs_t   ex [5];
        obs_t   e;
        st[0] = wr(FUNC_STORE, 0, 0);                   ex[0] = exv(0, 0, 0, 0, FUNC_NONE);
        st[1] = wr(FUNC_ALU, 3, 0);                     ex[1] = exv(0, 0, 0, 0, FUNC_STORE);
        st[2] = wr(FUNC_ALU, 3, 0);                     ex[2] = exv(0, 0, 0, 0, FUNC_ALU);
        st[3] = rd(FUNC_ALU, 0, 1, 0, 3, 1, 0, 7, 1);   ex[3] = exv(0, 0, 1, 0, FUNC_ALU);
        st[4] = rd(FUNC_ALU, 0, 0, 0, 3, 0, 0, 8, 1);   ex[4] = exv(0, 0, 0, 0, FUNC_ALU);
        for (int i = 0; i < 5; i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL youngest[%0d]: got %s, expected %s", i, show(obs), show(e));
            end
            step();
        end
        drain();
    endtask

    task automatic test_md_stall();
        obs_t e;
        int   n;
        int   exp_n;
        for (int p = 0; p < 2; p++) begin
            drive(mdi((p == 0) ? MD_OP_DIV : MD_OP_MULT, FUNC_MD, 0));
            sb.push_back(exv(0, 0, 0, 0, (p == 0) ? FUNC_NONE : FUNC_MOVE));
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL md_issue[%0d]: got %s, expected %s", p, show(obs), show(e));
            end
            step();
            drive(mdi(MD_OP_HILO, FUNC_MOVE, 8));
            cnt_sb.push_back((p == 0) ? DIV_C : MULT_C);
            sb.push_back(exv(0, 0, 0, 0, FUNC_NONE));
            n = 0;
            while (n < 40) begin
                @(negedge clk);
                if (!stall) break;
                n++;
                step();
            end
            exp_n = cnt_sb.pop_front();
            checks++;
            if (n !== exp_n) begin
                errors++;
                $display("FAIL md_stall_cycles[%0d]: got %0d, expected %0d", p, n, exp_n);
            end
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL md_release[%0d]: got %s, expected %s", p, show(obs), show(e));
            end
            step();
        end
        drain();
    endtask

    task automatic test_flush_stall();
        instr_t st [7];
        obs_t   ex [7];
        obs_t   e;
        st[0] = mdi(MD_OP_MULT, FUNC_MD, 0);            ex[0] = exv(0, 0, 0, 0, FUNC_NONE);
        st[1] = wr(FUNC_LOAD, 1, 2);                    ex[1] = exv(0, 0, 0, 1, FUNC_MD);
        st[2] = rd(FUNC_LOAD, 1, 1, 1, 0, 0, 0, 9, 2);  ex[2] = exv(1, 0, 0, 1, FUNC_LOAD);
        st[2].fl = 1'b1;
        st[3] = rd(FUNC_ALU, 0, 0, 0, 9, 1, 0, 10, 1);  ex[3] = exv(0, 0, 0, 1, FUNC_NONE);
        st[4] = bub();                                  ex[4] = exv(0, 0, 0, 1, FUNC_ALU);
        st[5] = bub();                                  ex[5] = exv(0, 0, 0, 1, FUNC_NONE);
        st[6] = bub();                                  ex[6] = exv(0, 0, 0, 0, FUNC_NONE);
        for (int i = 0; i < 7; i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL flush_stall[%0d]: got %s, expected %s", i, show(obs), show(e));
            end
            step();
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_reset_mid_div();
        test_load_use();
        test_branch_fwd();
        test_youngest();
        test_md_stall();
        test_flush_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached with %0d checks done", checks);
        $fatal(1);
    end

endmodule
